// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: sends each accepted 32-bit word as 4 bytes, LSB byte and LSB bit first.
// Define UART_TX_SYNC_BYTE_EN to precede every word with a 0xA5 sync byte.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx_serial,
  output logic        busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_SYNC_BYTE_EN
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, SYNC} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [1:0]        byte_idx, byte_n;
  logic [31:0]       shreg, shreg_n;
  logic              tx_n;
  logic              baud_end;
  logic [2:0]        next_bit;

  assign word_ready = (state == IDLE);
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign next_bit   = bit_cnt[2:0] + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      byte_idx  <= byte_n;
      shreg     <= shreg_n;
      tx_serial <= tx_n;
      busy      <= (state_n != IDLE);
    end
  end

  // tx_n is the line level for the state being entered, so the line is registered with it
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    shreg_n = shreg;
    tx_n    = tx_serial;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (word_valid) begin
          shreg_n = word_data;
          byte_n  = '0;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
`ifdef UART_TX_SYNC_BYTE_EN
          state_n = SYNC;
`else
          state_n = START;
`endif
        end
      end
`ifdef UART_TX_SYNC_BYTE_EN
      // bit_cnt 0 = start, 1..8 = data, 9 = stop of the sync frame
      SYNC: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_cnt == 4'd9) begin
            bit_n   = '0;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            bit_n = bit_cnt + 4'd1;
            tx_n  = (bit_cnt == 4'd8) ? 1'b1 : SYNC_BYTE[bit_cnt[2:0]];
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
`endif
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_cnt == 4'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 4'd1;
            tx_n  = shreg[next_bit];
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (byte_idx == 2'd3) begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end else begin
            byte_n  = byte_idx + 2'd1;
            shreg_n = {8'h00, shreg[31:8]};
            state_n = START;
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
